problem_3_1: RTL and testbench



---
 rtl/problem_3_1.sv | 119 +++++++++++
 tb/tb_problem_3_1.sv | 137 +++++++++++++
 2 files changed

// File: rtl/problem_3_1.sv
// ----------------------------------------------------------------------------
// problem_3_1 : switch-bank front end
//   Synchronises four asynchronous slide switches into the clk domain and
//   drives three indicator lights with the number of switches that are on
//   (0..4). The count is taken from a register, so there is no combinational
//   path from switches to lights.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous, active-low reset
//   switches  in   4  raw switch levels (asynchronous to clk)
//   lights    out  3  registered population count of the accepted switches
//
// Parameters
//   SYNC_STAGES      synchroniser depth (2..4)
//   DEBOUNCE_CYCLES  edges a new value must persist (1..255), debounce only
//
// Build option
//   PROBLEM_3_1_DEBOUNCE_EN : inserts a debounce stage between the
//   synchroniser and the count logic. Undefined by default.
// ----------------------------------------------------------------------------
module problem_3_1 #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] switches,
    output logic [2:0] lights
);

    localparam int unsigned SW_W  = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LED_W = 3;

    // Elaboration-time parameter range guard
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_check
        $error("problem_3_1: parameter out of range");
    end

    // Switch synchroniser: plain flop chain, no logic between stages
    logic [SYNC_STAGES-1:0][SW_W-1:0] sync_q;
    logic [SW_W-1:0]                  sync_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= switches;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    logic [SW_W-1:0] accepted;

`ifdef PROBLEM_3_1_DEBOUNCE_EN
    logic [SW_W-1:0]  acc_q, acc_d;
    logic [SW_W-1:0]  prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count edges where a new value is both different and unchanged;
    // accept it once the run length reaches DEBOUNCE_CYCLES
    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if ((sync_last != acc_q) && (sync_last == prev_q)) begin
            if (({1'b0, cnt_q} + 9'd1) == 9'(DEBOUNCE_CYCLES)) begin
                acc_d = sync_last;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            prev_q <= sync_last;
            cnt_q  <= cnt_d;
        end
    end

    assign accepted = acc_q;
`else
    assign accepted = sync_last;
`endif

    // Population count of the accepted value
    logic [LED_W-1:0] count_c;

    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(SW_W); i++) begin
            count_c = count_c + LED_W'(accepted[i]);
        end
    end

    logic [LED_W-1:0] lights_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lights_q <= '0;
        end else begin
            lights_q <= count_c;
        end
    end

    assign lights = lights_q;

endmodule

// File: tb/tb_problem_3_1.sv
// ----------------------------------------------------------------------------
// tb_problem_3_1 : self-checking bench for problem_3_1 (default parameters).
// Inputs change on the falling edge; the expected count for each driven value
// is queued and compared against lights once the pipeline latency has passed.
// ----------------------------------------------------------------------------
module tb_problem_3_1;

    localparam int unsigned SYNC_STAGES     = 2;
    localparam int unsigned DEBOUNCE_CYCLES = 4;
`ifdef PROBLEM_3_1_DEBOUNCE_EN
    localparam int unsigned LAT = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
    localparam int unsigned LAT = SYNC_STAGES;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] switches;
    logic [2:0] lights;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];

    problem_3_1 #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .switches(switches),
        .lights  (lights)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: lights=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive a switch value and queue the count it must eventually produce
    task automatic drive_push(input logic [3:0] sw);
        switches = sw;
        exp_q.push_back(3'($countones(sw)));
    endtask

    // Empty pipeline after reset: LAT leading zero counts
    task automatic sb_restart();
        exp_q.delete();
        for (int i = 0; i < int'(LAT); i++) exp_q.push_back(3'd0);
    endtask

    // One cycle: compare the oldest due result, then drive the next value
    task automatic step(input string tag, input logic [3:0] sw);
        logic [2:0] e;
        @(negedge clk);
        if (exp_q.size() == LAT + 1) begin
            e = exp_q.pop_front();
            check_eq(tag, lights, e);
        end
        drive_push(sw);
    endtask

    // One cycle with a fixed expectation, bypassing the scoreboard
    task automatic step_direct(input string tag, input logic [3:0] sw, input logic [2:0] exp);
        @(negedge clk);
        check_eq(tag, lights, exp);
        switches = sw;
    endtask

    initial begin
        logic [3:0] sweep [9];
        sweep = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};

        // Reset held with all switches on
        rst_n    = 1'b0;
        switches = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("reset_hold", lights, 3'd0);
        end

        // Release and start with all switches off
        rst_n = 1'b1;
        sb_restart();
        drive_push(4'h0);

        // Count sweep, each value held 10 cycles
        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < 10; c++) step("sweep", sweep[v]);
        end

        // Latency: clean step 0000 -> 0111
        for (int c = 0; c < 6; c++) step("lat_idle", 4'h0);
        for (int c = 0; c < 8; c++) step("lat_step", 4'h7);

        // Reach lights=4, then reset between edges
        for (int c = 0; c < 12; c++) step("pre_rst", 4'hF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", lights, 3'd0);
        @(negedge clk);
        check_eq("rst_low", lights, 3'd0);
        rst_n = 1'b1;
        sb_restart();
        drive_push(4'hF);
        for (int c = 0; c < 12; c++) step("post_rst", 4'hF);

`ifdef PROBLEM_3_1_DEBOUNCE_EN
        // Drain to idle, then a 3-cycle glitch must never show
        for (int c = 0; c < 15; c++) step("db_idle", 4'h0);
        step_direct("db_glitch", 4'h8, 3'd0);
        step_direct("db_glitch", 4'h8, 3'd0);
        step_direct("db_glitch", 4'h8, 3'd0);
        for (int c = 0; c < 15; c++) step_direct("db_glitch", 4'h0, 3'd0);
        // Sustained step to 1000 follows the full debounce latency
        sb_restart();
        drive_push(4'h0);
        for (int c = 0; c < 14; c++) step("db_step", 4'h8);
`else
        // Skewed bits: 0000 -> 0001 -> 1001 gives 0 -> 1 -> 2
        for (int c = 0; c < 6; c++) step("skew_idle", 4'h0);
        step("skew", 4'h1);
        for (int c = 0; c < 8; c++) step("skew", 4'h9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
